// File: rtl/lsm_sample_sender_pkg.sv
// Shared LSM fixed-point definitions: Q-format defaults, sample layout and
// the sender's FSM encoding.
package lsm_sample_sender_pkg;

  localparam int LSM_WIDTH = 32;
  localparam int LSM_QINT  = 16;
  localparam int LSM_QFRAC = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } lsm_state_e;

  // Reference sample layout at the default width; the sender mirrors this
  // field order for its WIDTH-parameterised storage word.
  typedef struct packed {
    logic signed [LSM_WIDTH-1:0] x;
    logic signed [LSM_WIDTH-1:0] y;
    logic                        last;
  } lsm_sample_t;

endpackage

// File: rtl/lsm_sample_sender_fifo.sv
// Small synchronous FIFO with registered read/write pointers.
// One extra pointer bit separates the full and empty conditions.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  // Head reads as zero while empty so stale entries never leak out.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/lsm_sample_sender.sv
// Filters Monte-Carlo paths to in-the-money put samples and streams them,
// buffered, to the least-squares accumulator in batches of N_SAMPLES.
module lsm_sample_sender
  import lsm_sample_sender_pkg::*;
#(
  parameter int WIDTH      = LSM_WIDTH,
  parameter int QINT       = LSM_QINT,
  parameter int QFRAC      = LSM_QFRAC,
  parameter int N_SAMPLES  = 10,
  parameter int MAX_PATHS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic signed [WIDTH-1:0]        strike,
  input  logic                           path_valid,
  output logic                           path_ready,
  input  logic signed [WIDTH-1:0]        s_in,
  input  logic signed [WIDTH-1:0]        cf_in,
  output logic                           valid_out,
  input  logic                           ready_in,
  output logic signed [WIDTH-1:0]        x_out,
  output logic signed [WIDTH-1:0]        y_out,
  output logic                           last_out,
  output logic                           busy,
  output logic                           batch_done,
  output logic                           batch_short,
  output logic [$clog2(N_SAMPLES+1)-1:0] itm_count
);
  localparam int IW = $clog2(N_SAMPLES+1);
  localparam int PW = $clog2(MAX_PATHS+1);

  typedef struct packed {
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic                    last;
  } smp_t;
  localparam int DW = $bits(smp_t);

  always_comb assert (QINT + QFRAC == WIDTH);

  lsm_state_e              state_q, state_d;
  logic signed [WIDTH-1:0] strike_q;
  logic [IW-1:0]           itm_q;
  logic [PW-1:0]           paths_q;
  logic                    consume, itm_hit, last_push;
  logic                    fifo_full, fifo_empty, pop;
  smp_t                    wr_smp, rd_smp;
  logic [DW-1:0]           rd_data;

  always_comb begin
    state_d     = state_q;
    path_ready  = 1'b0;
    consume     = 1'b0;
    itm_hit     = 1'b0;
    last_push   = 1'b0;
    batch_done  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_FILL;
      ST_FILL: begin
        path_ready = !fifo_full;
        consume    = path_valid && !fifo_full;
        itm_hit    = consume && (strike_q > s_in);
        last_push  = itm_hit && (itm_q == IW'(N_SAMPLES-1));
        // A last push and the path budget running out together still count
        // as a full batch: itm_q reaches N_SAMPLES either way.
        if (last_push || (consume && paths_q == PW'(MAX_PATHS-1)))
          state_d = ST_DRAIN;
      end
      ST_DRAIN: if (fifo_empty) begin
        batch_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign batch_short = batch_done && (itm_q != IW'(N_SAMPLES));
  assign busy        = (state_q != ST_IDLE);
  assign itm_count   = itm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      strike_q <= '0;
      itm_q    <= '0;
      paths_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        strike_q <= strike;
        itm_q    <= '0;
        paths_q  <= '0;
      end
      if (consume) paths_q <= paths_q + 1'b1;
      if (itm_hit) itm_q   <= itm_q + 1'b1;
    end
  end

  assign wr_smp    = '{x: s_in, y: cf_in, last: last_push};
  assign pop       = !fifo_empty && ready_in;
  assign rd_smp    = smp_t'(rd_data);
  assign valid_out = !fifo_empty;
  assign x_out     = rd_smp.x;
  assign y_out     = rd_smp.y;
  assign last_out  = rd_smp.last;

  sample_fifo #(.DEPTH(FIFO_DEPTH), .DW(DW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (itm_hit),
    .wr_data (wr_smp),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: doc/lsm_sample_sender.md
LSM_SAMPLE_SENDER -- requirements
Module: lsm_sample_sender

Interface
REQ-001 SHALL have parameter WIDTH, default 32, sample word width.
REQ-002 SHALL have parameter QINT, default 16, integer bits (Q16.16).
REQ-003 SHALL have parameter QFRAC, default 16, fractional bits.
REQ-004 SHALL have parameter N_SAMPLES, default 10, in-the-money (ITM) samples per batch.
REQ-005 SHALL have parameter MAX_PATHS, default 64, path budget per batch (MAX_PATHS >= N_SAMPLES).
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, power of two, >= 2.
REQ-007 SHALL have ports clk input 1, sole clock; rst input 1, asynchronous active-high reset.
REQ-008 SHALL have ports start input 1, one-cycle batch start pulse; strike input WIDTH signed, put strike, sampled at start.
REQ-009 SHALL have ports path_valid input 1, path_ready output 1, s_in input WIDTH signed (spot price), cf_in input WIDTH signed (discounted cashflow).
REQ-010 SHALL have ports valid_out output 1, ready_in input 1, x_out output WIDTH signed, y_out output WIDTH signed, last_out output 1 (accumulator-facing).
REQ-011 SHALL have ports busy output 1, batch_done output 1 pulse, batch_short output 1 pulse, itm_count output $clog2(N_SAMPLES+1).

Function
REQ-012 SHALL implement FSM IDLE -> FILL -> DRAIN -> IDLE; start ignored outside IDLE.
REQ-013 SHALL, in IDLE on start, latch strike, clear path and ITM counters and enter FILL the next cycle.
REQ-014 SHALL drive path_ready = (state==FILL) && !fifo_full; a path is consumed when path_valid && path_ready.
REQ-015 SHALL classify a consumed path as ITM iff strike_q > s_in (signed, strict); ITM paths are pushed as {x=s_in, y=cf_in, last}, OTM paths are dropped.
REQ-016 SHALL set the pushed last flag iff the push is the N_SAMPLES-th ITM push of the batch.
REQ-017 SHALL leave FILL for DRAIN the cycle after the N_SAMPLES-th ITM push, or after the MAX_PATHS-th consumed path, whichever comes first (same cycle: full batch, not short).
REQ-018 SHALL present FIFO head on x_out/y_out/last_out with valid_out = !fifo_empty; accepted ITM path visible one cycle after consumption.
REQ-019 SHALL pop on valid_out && ready_in; x_out, y_out, last_out SHALL be stable while valid_out && !ready_in.
REQ-020 SHALL, in DRAIN with FIFO empty, pulse batch_done one cycle and return to IDLE; batch_short pulses with batch_done iff fewer than N_SAMPLES ITM samples were pushed (no last_out sent).
REQ-021 SHALL support simultaneous push and pop in one cycle; occupancy unchanged.
REQ-022 SHALL never push when full (guaranteed by REQ-014) nor pop when empty.
REQ-023 SHALL drive busy = (state != IDLE) and itm_count = ITM pushes in current batch, held after done until next start.

Reset
REQ-024 SHALL on rst: state IDLE, FIFO empty, counters 0, path_ready 0, valid_out 0, last_out 0, x_out/y_out 0, busy 0, batch_done 0, batch_short 0, itm_count 0.
REQ-025 SHALL on rst mid-batch discard all buffered samples; no valid_out until a new start.

Structure
REQ-026 SHALL take WIDTH/QINT/QFRAC defaults and the sample struct {x, y, last} from the shared LSM fixed-point package.
REQ-027 SHALL instantiate one sub-module sample_fifo (parameterised depth/width, registered pointers, full/empty flags).

Verification
REQ-028 SHALL verify N_SAMPLES=4, strike=100.0, paths s=90,110,95,80,120,70 (cf=5..10), ready_in=1 -> x_out 90,95,80,70 in order, last_out only with 70, batch_done 1, batch_short 0, itm_count 4.
REQ-029 SHALL verify ready_in held low 10 cycles with 4 ITM paths offered -> path_ready low once FIFO holds 4, x_out/y_out stable, no sample lost after release.
REQ-030 SHALL verify MAX_PATHS=8, N_SAMPLES=4, only 2 ITM among 8 paths -> 2 samples, last_out never 1, batch_done and batch_short same cycle.
REQ-031 SHALL verify s_in == strike (100.0) -> dropped; negative cf_in=-1.0 on ITM path -> y_out=0xFFFF0000.
REQ-032 SHALL verify rst pulse with 3 samples buffered mid-FILL -> valid_out 0 next cycle, state IDLE; start then runs a clean full batch.
REQ-033 SHALL verify start asserted during FILL/DRAIN ignored and strike change mid-batch has no effect on classification.
